// File: rtl/fuzz_sig_pkg.sv
// Shared types and helpers for the fuzz output signature block.
// The chunk fold is exposed here so a reference model can reuse it.
package fuzz_sig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sig_state_e;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;

    // Upper bounds accepted by fold_chunks; callers zero-extend into these.
    localparam int MAX_OUT_W = 1024;
    localparam int MAX_SIG_W = 64;
    localparam int OUT_IDX_W = $clog2(MAX_OUT_W);
    localparam int SIG_IDX_W = $clog2(MAX_SIG_W);

    // XOR of all sig_w-bit chunks of the low out_w bits of data; bits past
    // out_w act as zero padding. Meant to be called with constant widths.
    function automatic logic [MAX_SIG_W-1:0] fold_chunks(
        input logic [MAX_OUT_W-1:0] data,
        input int unsigned          out_w,
        input int unsigned          sig_w
    );
        logic [MAX_SIG_W-1:0] acc;
        logic [OUT_IDX_W-1:0] bit_idx;
        logic [SIG_IDX_W-1:0] acc_idx;
        acc = '0;
        for (int i = 0; i < MAX_OUT_W; i++) begin
            bit_idx = OUT_IDX_W'(i);
            acc_idx = SIG_IDX_W'(32'(i) % sig_w);
            if (32'(i) < out_w) begin
                acc[acc_idx] = acc[acc_idx] ^ data[bit_idx];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/fuzz_sig_misr.sv
// Multiple-input signature register: shift-left Galois LFSR with the
// folded sample XORed in on every step; load reseeds.
module fuzz_sig_misr
    import fuzz_sig_pkg::*;
#(
    parameter int             SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY),
    parameter logic [SIG_W-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_next;

    always_comb begin
        w_next = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= SEED;
        end else if (load) begin
            r_sig <= SEED;
        end else if (step) begin
            r_sig <= w_next;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/fuzz_out_signature.sv
// Capture stage: folds each sampled DUT output vector into a MISR signature
// and counts samples, publishing the result through a valid/ready handshake.
module fuzz_out_signature
    import fuzz_sig_pkg::*;
#(
    parameter int               OUT_W = 330,
    parameter int               SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY),
    parameter logic [SIG_W-1:0] SEED  = '1,
    parameter int               CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [OUT_W-1:0] dut_out,
    input  logic             flush,
    output logic             sig_valid,
    input  logic             sig_ready,
    output logic [SIG_W-1:0] sig_data,
    output logic [CNT_W-1:0] sig_cycles,
    output logic             busy,
    output sig_state_e       dbg_state
);

    sig_state_e        r_state;
    logic [SIG_W-1:0]  r_fold_q;
    logic              r_fold_v;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;
    logic              r_busy;

    logic [SIG_W-1:0]  w_fold;
    logic              w_load;
    logic              w_step;
    logic [SIG_W-1:0]  w_sig;

    assign w_fold = SIG_W'(fold_chunks(MAX_OUT_W'(dut_out), OUT_W, SIG_W));

    // A reseed discards any stage-1 entry still in flight.
    assign w_load = start && ((r_state == IDLE) || (r_state == ACCUM));
    assign w_step = r_fold_v && !w_load;

    fuzz_sig_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .step (w_step),
        .din  (r_fold_q),
        .sig  (w_sig)
    );

    // Result handshake: sig_valid rises on entering DONE and holds, together
    // with sig_data/sig_cycles, until a cycle where sig_ready is also high;
    // that edge completes the transfer and returns the block to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_fold_q <= '0;
            r_fold_v <= 1'b0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_fold_q <= w_fold;
            if (w_step) begin
                r_cnt <= (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    r_fold_v <= 1'b0;
                    if (start) begin
                        r_state <= ACCUM;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (start) begin
                        r_fold_v <= 1'b0;
                        r_cnt    <= '0;
                    end else begin
                        r_fold_v <= en;
                        if (flush) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    r_fold_v <= 1'b0;
                    r_state  <= DONE;
                    r_busy   <= 1'b0;
                    r_valid  <= 1'b1;
                end
                DONE: begin
                    r_fold_v <= 1'b0;
                    if (r_valid && sig_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_fold_v <= 1'b0;
                    r_valid  <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign sig_valid  = r_valid;
    assign sig_data   = w_sig;
    assign sig_cycles = r_cnt;
    assign busy       = r_busy;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_fuzz_out_signature.sv
// Directed bench for fuzz_out_signature with hand-computed signatures and a
// small independent MISR model for multi-sample captures.
module tb_fuzz_out_signature;
    import fuzz_sig_pkg::*;

    localparam int OUT_W = 330;
    localparam int SIG_W = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             en;
    logic [OUT_W-1:0] dut_out;
    logic             flush;
    logic             sig_valid;
    logic             sig_ready;
    logic [SIG_W-1:0] sig_data;
    logic [CNT_W-1:0] sig_cycles;
    logic             busy;
    sig_state_e       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    fuzz_out_signature dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .en         (en),
        .dut_out    (dut_out),
        .flush      (flush),
        .sig_valid  (sig_valid),
        .sig_ready  (sig_ready),
        .sig_data   (sig_data),
        .sig_cycles (sig_cycles),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_fold(input logic [OUT_W-1:0] v);
        logic [351:0] padded;
        logic [31:0]  acc;
        padded = {22'b0, v};
        acc = '0;
        for (int k = 0; k < 11; k++) acc = acc ^ padded[k*32 +: 32];
        return acc;
    endfunction

    function automatic logic [31:0] model_step(input logic [31:0] s, input logic [31:0] f);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_sample(input logic [OUT_W-1:0] v, input logic with_flush);
        en = 1'b1;
        dut_out = v;
        flush = with_flush;
        tick();
        en = 1'b0;
        flush = 1'b0;
        dut_out = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(sig_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_data"}, 64'(sig_data), 64'hFFFFFFFF);
        check({tag, "_cycles"}, 64'(sig_cycles), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    // Flush (optionally with a final sample), verify the two-cycle result
    // latency and values, then complete the handshake.
    task automatic finish_capture(input string tag, input logic [31:0] exp_sig,
                                  input logic [31:0] exp_cnt, input logic with_sample,
                                  input logic [OUT_W-1:0] v);
        if (with_sample) begin
            do_sample(v, 1'b1);
        end else begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        check({tag, "_drain_valid"}, 64'(sig_valid), 64'd0);
        check({tag, "_drain_busy"}, 64'(busy), 64'd1);
        tick();
        check({tag, "_valid"}, 64'(sig_valid), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_data"}, 64'(sig_data), 64'(exp_sig));
        check({tag, "_cycles"}, 64'(sig_cycles), 64'(exp_cnt));
        sig_ready = 1'b1;
        tick();
        sig_ready = 1'b0;
        check({tag, "_ack_valid"}, 64'(sig_valid), 64'd0);
        check({tag, "_ack_state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    initial begin
        logic [OUT_W-1:0] v_a;
        logic [OUT_W-1:0] v_b;
        logic [OUT_W-1:0] v_c;
        logic [31:0]      m_sig;
        logic [31:0]      held_sig;
        logic [31:0]      held_cnt;

        rst = 1'b1;
        start = 1'b0;
        en = 1'b0;
        flush = 1'b0;
        sig_ready = 1'b0;
        dut_out = '0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Empty capture.
        do_start();
        check("empty_busy", 64'(busy), 64'd1);
        check("empty_state", 64'(dbg_state), 64'(ACCUM));
        tick();
        finish_capture("empty", 32'hFFFFFFFF, 32'd0, 1'b0, '0);

        // Single zero sample.
        do_start();
        do_sample('0, 1'b0);
        finish_capture("zero", 32'hFB3EE249, 32'd1, 1'b0, '0);

        // Bits 0 and 32 cancel in the fold.
        v_a = '0;
        v_a[0] = 1'b1;
        v_a[32] = 1'b1;
        do_start();
        do_sample(v_a, 1'b0);
        finish_capture("cancel", 32'hFB3EE249, 32'd1, 1'b0, '0);

        // Top bit lands in bit 9 of the last, padded chunk.
        v_b = '0;
        v_b[329] = 1'b1;
        do_start();
        do_sample(v_b, 1'b0);
        finish_capture("topbit", 32'hFB3EE049, 32'd1, 1'b0, '0);

        // Three samples then en+flush together: fourth sample is included.
        v_c = {10{33'h1_2345_6789}};
        m_sig = 32'hFFFFFFFF;
        m_sig = model_step(m_sig, model_fold(v_b));
        m_sig = model_step(m_sig, model_fold(v_a));
        m_sig = model_step(m_sig, model_fold(v_c));
        m_sig = model_step(m_sig, model_fold(v_b));
        do_start();
        do_sample(v_b, 1'b0);
        do_sample(v_a, 1'b0);
        do_sample(v_c, 1'b0);
        finish_capture("enflush", m_sig, 32'd4, 1'b1, v_b);

        // start+flush together in ACCUM: reseed wins, pending sample dropped.
        do_start();
        do_sample(v_c, 1'b0);
        do_sample(v_c, 1'b0);
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("reseed_busy", 64'(busy), 64'd1);
        check("reseed_state", 64'(dbg_state), 64'(ACCUM));
        check("reseed_cycles", 64'(sig_cycles), 64'd0);
        tick();
        tick();
        check("reseed_novalid", 64'(sig_valid), 64'd0);
        check("reseed_cycles2", 64'(sig_cycles), 64'd0);
        do_sample('0, 1'b0);
        finish_capture("reseed", 32'hFB3EE249, 32'd1, 1'b0, '0);

        // Backpressure: result holds for 10 cycles, start in DONE ignored.
        m_sig = model_step(32'hFFFFFFFF, model_fold(v_c));
        m_sig = model_step(m_sig, model_fold(v_a));
        do_start();
        do_sample(v_c, 1'b0);
        do_sample(v_a, 1'b1);
        tick();
        held_sig = m_sig;
        held_cnt = 32'd2;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) start = 1'b1;
            check("bp_valid", 64'(sig_valid), 64'd1);
            check("bp_data", 64'(sig_data), 64'(held_sig));
            check("bp_cycles", 64'(sig_cycles), 64'(held_cnt));
            check("bp_state", 64'(dbg_state), 64'(DONE));
            tick();
            start = 1'b0;
        end
        sig_ready = 1'b1;
        tick();
        sig_ready = 1'b0;
        check("bp_ack_valid", 64'(sig_valid), 64'd0);
        check("bp_ack_state", 64'(dbg_state), 64'(IDLE));
        check("bp_ack_busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-capture after 50 samples.
        do_start();
        for (int i = 0; i < 50; i++) begin
            do_sample({10{33'(i * 7919 + 3)}}, 1'b0);
        end
        check("pre_rst_cycles", 64'(sig_cycles), 64'd49);
        #3;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        #2;
        rst = 1'b0;
        tick();
        check_idle_outputs("post_rst");
        do_start();
        do_sample('0, 1'b0);
        finish_capture("after_rst", 32'hFB3EE249, 32'd1, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fuzz_out_signature.md
# fuzz_out_signature

Downstream capture stage for the fuzz harness: consumes the DUT's flat output vector every sampled cycle and compacts it into a fixed-width MISR signature plus a sample count. Cross-simulator comparison then diffs one word per run instead of a per-cycle output log. Fully synthesizable; sits between the DUT `out_flat` and the bench's result reporting.

## Interface
- `OUT_W`, 330: width of the DUT output vector consumed.
- `SIG_W`, 32: signature width (≥ 8).
- `POLY`, 32'h04C11DB7: MISR feedback polynomial, `SIG_W` bits.
- `SEED`, all-ones: signature value loaded on start.
- `CNT_W`, 32: sample counter width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: pulse; begins a new capture.
- `en` in 1: sample `dut_out` this cycle.
- `dut_out` in `OUT_W`: DUT output vector.
- `flush` in 1: pulse; end capture and publish result.
- `sig_valid` out 1: result available.
- `sig_ready` in 1: consumer accepts result.
- `sig_data` out `SIG_W`: final signature.
- `sig_cycles` out `CNT_W`: number of samples folded in.
- `busy` out 1: high in ACCUM or DRAIN.

## Operation
- Fold: `dut_out` zero-padded to ceil(`OUT_W`/`SIG_W`)·`SIG_W` bits, XOR of all `SIG_W`-bit chunks → `fold`. For the defaults: 11 chunks, top 22 bits zero.
- Stage 1 register: `fold_q` <= `fold`, `fold_v` <= `en` while in ACCUM (`fold_v` = 0 otherwise).
- Stage 2 MISR, when `fold_v`: `sig` <= ({`sig`[SIG_W-2:0],0} ^ (`sig`[SIG_W-1] ? `POLY` : 0)) ^ `fold_q`; `cnt` <= `cnt`+1, saturating at all-ones.
- FSM:
  - IDLE: `start` → ACCUM; `sig` <= `SEED`, `cnt` <= 0, `fold_v` cleared. `flush` and `en` are ignored.
  - ACCUM: `flush` → DRAIN. `start` → stays in ACCUM and reseeds as above; `start` wins over a simultaneous `flush`; the pending `fold_v` is discarded.
  - DRAIN: one cycle; the last stage-1 entry is absorbed → DONE.
  - DONE: `sig_valid`=1, `sig_data`/`sig_cycles` hold stable. `sig_valid`&&`sig_ready` → IDLE. `start` in DONE is ignored until the handshake completes.
- `en` together with `flush` in ACCUM: that sample is included.
- `sig_data`/`sig_cycles` are driven from `sig`/`cnt` continuously and are only meaningful while `sig_valid`.

## Timing
- Reset values: `sig_valid`=0, `busy`=0, `sig_data`=`SEED`, `sig_cycles`=0, state IDLE, `fold_v`=0.
- Reset asserted mid-capture aborts immediately: all state returns to reset values, and no result is published.
- Sample latency: `en` at cycle N updates `sig` at the end of cycle N+1.
- `flush` sampled at cycle N → DRAIN in N+1 → `sig_valid`=1 from N+2.
- `sig_valid` stays high until accepted and then drops the cycle after the handshake; the earliest new `start` is accepted the cycle after that.
- Outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package `fuzz_sig_pkg`:
  - FSM state enum `sig_state_e` {IDLE, ACCUM, DRAIN, DONE};
  - default `POLY`/`SEED` constants;
  - function `fold_chunks` (parameterised by width) for reuse by the bench model.
- One sub-module `fuzz_sig_misr`: SIG_W/POLY/SEED parameters, `load`, `step`, `din`, `sig` out.
- The top-level holds the fold, stage-1 register, FSM and counter.

## Test plan
- Empty capture: `start`, then no `en`, then `flush` → `sig_valid` two cycles after `flush`, `sig_data`=32'hFFFFFFFF, `sig_cycles`=0.
- Single zero sample: `start`, one `en` with `dut_out`=0, `flush` → `sig_data`=32'hFB3EE249, `sig_cycles`=1.
- Fold cancellation and padding:
  - `dut_out` with bits 0 and 32 set, one sample → 32'hFB3EE249.
  - `dut_out` with only bit 329 set → 32'hFB3EE049.
- Simultaneous events:
  - `en`+`flush` in the same cycle after 3 prior samples → `sig_cycles`=4.
  - `start`+`flush` in the same cycle → stays busy with `cnt`=0 and no `sig_valid`.
- Backpressure: hold `sig_ready`=0 for 10 cycles → `sig_valid`, `sig_data` and `sig_cycles` stable. Pulse `start` meanwhile → ignored. Then `sig_ready`=1 → IDLE the next cycle.
- Reset mid-ACCUM after 50 samples, asserted asynchronously between edges → outputs return to reset values at once. Next capture of 1 zero sample → 32'hFB3EE249.
